// File: rtl/memref_pkg.sv
// Shared types and helpers for the memref read streamer.
package memref_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Address width for a memref of the given depth (never less than 1 bit)
  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/memref_fifo.sv
// Small synchronous FIFO buffering read responses ahead of the output stream.
module memref_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (cnt_q == (PW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop && !empty;
    // A push into a full FIFO is still legal when the head leaves in the same cycle
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
    count   = cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/memref_rd_streamer.sv
// Issues a burst of reads to a memref port and streams the responses out
// through a credit-controlled FIFO with ready/valid handshake.
module memref_rd_streamer
  import memref_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = addr_w(SIZE),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  output logic             rd_en,
  output logic [AW-1:0]    addr,
  input  logic             dout_valid,
  input  logic [WIDTH-1:0] dout,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [AW-1:0]    addr_q;
  logic [AW:0]      rem_q;
  logic [AW:0]      count_q;
  logic [AW:0]      pop_cnt;
  logic             outstanding;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic             issue;
  logic             credit_ok;
  logic             head_last;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_cnt;

  memref_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dout),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    accept    = (state == ISSUE) || (state == DRAIN);
    push      = dout_valid && accept;
    // Reserve a FIFO slot for every read in flight so responses never overflow
    credit_ok = (int'(outstanding) + int'(fifo_cnt)) < FIFO_DEPTH;
    issue     = (state == ISSUE) && (rem_q != '0) && credit_ok;
    head_last = (pop_cnt == count_q - (AW+1)'(1));
    m_valid   = !fifo_empty;
    m_data    = fifo_empty ? '0 : fifo_dout;
    m_last    = m_valid && accept && head_last;
    pop       = m_valid && m_ready;
    rd_en     = issue;
    addr      = addr_q;
    busy      = busy_q;
    done      = done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      pop_cnt     <= '0;
      outstanding <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (issue)           outstanding <= 1'b1;
      else if (dout_valid) outstanding <= 1'b0;

      if (issue) begin
        addr_q <= (addr_q == AW'(SIZE - 1)) ? '0 : addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end

      if (pop) pop_cnt <= pop_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= base;
            count_q <= count;
            rem_q   <= count;
            pop_cnt <= '0;
            busy_q  <= 1'b1;
            if (count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue && (rem_q == (AW+1)'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_memref_rd_streamer.sv
// Scoreboard bench for memref_rd_streamer with a 1-cycle-latency memory model.
module tb_memref_rd_streamer;

  localparam int WIDTH = 32;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base;
  logic [AW:0]      count;
  logic             rd_en;
  logic [AW-1:0]    addr;
  logic             dout_valid;
  logic [WIDTH-1:0] dout;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;
  logic             busy;
  logic             done;

  memref_rd_streamer #(
    .WIDTH      (WIDTH),
    .SIZE       (SIZE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .count      (count),
    .rd_en      (rd_en),
    .addr       (addr),
    .dout_valid (dout_valid),
    .dout       (dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] exp_data [$];
  logic             exp_last [$];
  logic [AW-1:0]    exp_addr [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int rds = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int start_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Memory read port: response exactly one cycle after the strobe
  always @(posedge clk) begin
    logic          r_en;
    logic [AW-1:0] r_a;
    r_en = rd_en;
    r_a  = addr;
    #1;
    dout_valid = r_en;
    dout       = mem[r_a];
  end

  // Scoreboard monitor
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== hold_d) begin
          bad++;
          $display("FAIL hold_stable: m_valid=%b m_data=%0d required 1/%0d", m_valid, m_data, hold_d);
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;

      if (rd_en === 1'b1) begin
        logic [AW-1:0] ea;
        rds++;
        total++;
        if (exp_addr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rd: addr=%0d required no read", addr);
        end else begin
          ea = exp_addr.pop_front();
          if (addr !== ea) begin
            bad++;
            $display("FAIL rd_addr: addr=%0d required %0d", addr, ea);
          end
        end
      end

      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        logic [WIDTH-1:0] ed;
        logic             el;
        if (pops == 0) first_pop_cyc = cyc;
        pops++;
        last_pop_cyc = cyc;
        total++;
        if (exp_data.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: m_data=%0d required none", m_data);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          if (m_data !== ed || m_last !== el) begin
            bad++;
            $display("FAIL stream_word: data=%0d last=%b required %0d/%b", m_data, m_last, ed, el);
          end
        end
      end
    end
  end

  task automatic launch(input int b, input int c);
    int a;
    base  = AW'(b);
    count = (AW+1)'(c);
    start = 1'b1;
    for (int i = 0; i < c; i++) begin
      a = (b + i) % SIZE;
      exp_addr.push_back(AW'(a));
      exp_data.push_back(mem[a]);
      exp_last.push_back(i == c - 1);
    end
    pops = 0;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    total++;
    if (dcyc < 0) begin
      bad++;
      $display("FAIL done_timeout: done never seen, required within %0d cycles", budget);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_data.size() != 0 || exp_addr.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: words_left=%0d reads_left=%0d required 0/0", name, exp_data.size(), exp_addr.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({rd_en, busy, done, m_valid, m_last} !== 5'b0 || addr !== '0 || m_data !== '0) begin
      bad++;
      $display("FAIL %s: rd_en=%b busy=%b done=%b m_valid=%b m_last=%b addr=%0d m_data=%0d required all 0",
               name, rd_en, busy, done, m_valid, m_last, addr, m_data);
    end
  endtask

  task automatic test_reset();
    #2;
    check_idle_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    #2 rst = 1'b1;
  endtask

  task automatic test_basic();
    int d;
    m_ready = 1'b1;
    @(posedge clk); #1;
    launch(2, 4);
    wait_done(40, d);
    total++;
    if (first_pop_cyc !== start_cyc + 3) begin
      bad++;
      $display("FAIL basic_latency: first pop cycle=%0d required %0d", first_pop_cyc, start_cyc + 3);
    end
    total++;
    if (last_pop_cyc - first_pop_cyc !== 3 || pops !== 4) begin
      bad++;
      $display("FAIL basic_back_to_back: span=%0d pops=%0d required 3/4", last_pop_cyc - first_pop_cyc, pops);
    end
    total++;
    if (d !== last_pop_cyc + 1) begin
      bad++;
      $display("FAIL basic_done_timing: done cycle=%0d required %0d", d, last_pop_cyc + 1);
    end
    check_drained("basic");
  endtask

  task automatic test_wrap();
    bit seen = 0;
    @(posedge clk); #1;
    launch(6, 5);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wrap_done: done=0 required 1 within 100 cycles");
    end
    check_drained("wrap");
  endtask

  task automatic test_zero();
    int busy_cnt = 0;
    int dcyc = -1;
    int rd0;
    @(posedge clk); #1;
    rd0 = rds;
    launch(0, 0);
    repeat (3) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) dcyc = cyc;
    end
    total++;
    if (dcyc !== start_cyc + 1) begin
      bad++;
      $display("FAIL zero_done: done cycle=%0d required %0d", dcyc, start_cyc + 1);
    end
    total++;
    if (busy_cnt !== 1) begin
      bad++;
      $display("FAIL zero_busy: busy cycles=%0d required 1", busy_cnt);
    end
    total++;
    if (rds !== rd0) begin
      bad++;
      $display("FAIL zero_rd: reads=%0d required 0", rds - rd0);
    end
  endtask

  task automatic test_backpressure();
    int rd0;
    int d;
    m_ready = 1'b0;
    @(posedge clk); #1;
    rd0 = rds;
    launch(3, SIZE);
    repeat (19) @(negedge clk);
    total++;
    if (rds - rd0 !== DEPTH) begin
      bad++;
      $display("FAIL stall_reads: reads=%0d required %0d", rds - rd0, DEPTH);
    end
    total++;
    if (m_valid !== 1'b1 || m_data !== mem[3] || m_last !== 1'b0) begin
      bad++;
      $display("FAIL stall_head: valid=%b data=%0d last=%b required 1/%0d/0", m_valid, m_data, m_last, mem[3]);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(60, d);
    total++;
    if (pops !== SIZE) begin
      bad++;
      $display("FAIL full_burst_words: pops=%0d required %0d", pops, SIZE);
    end
    check_drained("backpressure");
  endtask

  task automatic test_restart_ignored();
    int d;
    m_ready = 1'b1;
    @(posedge clk); #1;
    launch(1, 3);
    base  = AW'(5);
    count = (AW+1)'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, d);
    repeat (6) @(negedge clk);
    total++;
    if (pops !== 3) begin
      bad++;
      $display("FAIL restart_words: pops=%0d required 3", pops);
    end
    check_drained("restart");
  endtask

  task automatic test_reset_mid();
    int d;
    bit seen = 0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    launch(0, 6);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk); #1;
      if (pops >= 2) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midreset_wait: pops=%0d required 2", pops);
    end
    #1 rst = 1'b0;
    #1;
    check_idle_outputs("midreset_async");
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    repeat (2) @(negedge clk);
    check_idle_outputs("midreset_held");
    #2 rst = 1'b1;
    launch(0, 2);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL first_start: busy=%b required 1", busy);
    end
    wait_done(30, d);
    repeat (4) @(negedge clk);
    total++;
    if (pops !== 2) begin
      bad++;
      $display("FAIL midreset_words: pops=%0d required 2", pops);
    end
    check_drained("midreset");
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(i + 100);
    rst        = 1'b0;
    start      = 1'b0;
    base       = '0;
    count      = '0;
    m_ready    = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
